// File: rtl/scsp_eg_if.sv
// Slot-envelope bus: per-slot parameters in, envelope strobe and monitor out.
interface scsp_eg_if;
  logic       ce;
  logic [4:0] slot;
  logic       kon;
  logic       koff;
  logic [4:0] ar;
  logic [4:0] d1r;
  logic [4:0] d2r;
  logic [4:0] rr;
  logic [4:0] dl;
  logic       eghold;
  logic       lpslnk;
  logic [3:0] krs;
  logic [3:0] oct;
  logic       loop;
  logic [4:0] mslc;
  logic [9:0] evol;
  logic [1:0] est;
  logic [4:0] out_slot;
  logic       out_valid;
  logic [4:0] mon_eg;
  logic [1:0] mon_sgc;

  modport master (
    output ce, slot, kon, koff, ar, d1r, d2r, rr, dl, eghold, lpslnk, krs, oct, loop, mslc,
    input  evol, est, out_slot, out_valid, mon_eg, mon_sgc
  );

  modport slave (
    input  ce, slot, kon, koff, ar, d1r, d2r, rr, dl, eghold, lpslnk, krs, oct, loop, mslc,
    output evol, est, out_slot, out_valid, mon_eg, mon_sgc
  );
endinterface

// File: rtl/scsp_eg.sv
// 32-slot time-multiplexed envelope generator (attack/decay1/decay2/release).
module scsp_eg (
  input  logic     clk,
  input  logic     rst_n,
  scsp_eg_if.slave bus
);
  localparam int unsigned NSLOT = 32;
  localparam int unsigned LVLW  = 10;
  localparam int unsigned CNTW  = 13;

  typedef enum logic [1:0] {
    ST_ATK = 2'b00,
    ST_D1  = 2'b01,
    ST_D2  = 2'b10,
    ST_REL = 2'b11
  } eg_state_e;

  eg_state_e       st_q  [NSLOT];
  logic [LVLW-1:0] lvl_q [NSLOT];
  logic [CNTW-1:0] smp_cnt_q;

  eg_state_e       st_cur, st_eff, st_nxt;
  logic [LVLW-1:0] lvl_cur, lvl_nxt, evol_nxt;
  logic [4:0]      rate, er, er_cap;
  logic [5:0]      key_t, rate_sum;
  logic [3:0]      ks, sh, step;
  logic [CNTW-1:0] gate_mask;
  logic            do_step;
  logic [10:0]     lvl_ext, dec, acc;

  // Envelope update of the slot presented on this CE.
  always_comb begin
    st_cur   = st_q[bus.slot];
    lvl_cur  = lvl_q[bus.slot];
    st_eff   = st_cur;
    rate     = 5'd0;
    key_t    = 6'd0;
    ks       = 4'd0;
    rate_sum = 6'd0;
    er       = 5'd0;
    er_cap   = 5'd0;
    sh       = 4'd0;
    gate_mask = '0;
    do_step  = 1'b0;
    step     = 4'd1;
    lvl_ext  = {1'b0, lvl_cur};
    dec      = 11'd0;
    acc      = 11'd0;
    lvl_nxt  = lvl_cur;
    st_nxt   = st_cur;
    evol_nxt = lvl_cur;

    // Key events override stored state; key-on has priority.
    if (bus.kon)       st_eff = ST_ATK;
    else if (bus.koff) st_eff = ST_REL;

    case (st_eff)
      ST_ATK:  rate = bus.ar;
      ST_D1:   rate = bus.d1r;
      ST_D2:   rate = bus.d2r;
      default: rate = bus.rr;
    endcase

    // Key scaling: KRS + signed octave, clamped to 0..15; KRS=F disables it.
    key_t = 6'({2'b00, bus.krs}) + 6'({{2{bus.oct[3]}}, bus.oct});
    if (bus.krs == 4'hF) ks = 4'd0;
    else if (key_t[5])   ks = 4'd0;
    else if (key_t[4])   ks = 4'hF;
    else                 ks = key_t[3:0];

    rate_sum = {1'b0, rate} + {2'b00, ks};
    er       = (rate_sum > 6'd31) ? 5'd31 : rate_sum[4:0];
    er_cap   = (er > 5'd24) ? 5'd24 : er;
    sh       = 4'((5'd24 - er_cap) >> 1);
    gate_mask = (13'd1 << sh) - 13'd1;
    do_step  = (rate != 5'd0) && ((smp_cnt_q & gate_mask) == '0);
    step     = (er > 5'd24) ? (4'd1 << 2'((er - 5'd24) >> 1)) : 4'd1;

    if (do_step) begin
      if (st_eff == ST_ATK) begin
        if (er >= 5'd30) begin
          lvl_nxt = '0;
        end else begin
          dec     = 11'(lvl_cur >> 4) + 11'd1;
          lvl_nxt = (lvl_ext > dec) ? 10'(lvl_ext - dec) : '0;
        end
      end else begin
        acc     = lvl_ext + 11'(step);
        lvl_nxt = (acc > 11'h3FF) ? 10'h3FF : acc[9:0];
      end
    end

    st_nxt = st_eff;
    case (st_eff)
      ST_ATK:  if (bus.lpslnk ? bus.loop : (lvl_nxt == '0)) st_nxt = ST_D1;
      ST_D1:   if (lvl_nxt[9:5] >= bus.dl) st_nxt = ST_D2;
      default: st_nxt = st_eff;
    endcase

    evol_nxt = ((st_nxt == ST_ATK) && bus.eghold) ? '0 : lvl_nxt;
  end

  // Per-slot level/state storage and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]  <= ST_REL;
        lvl_q[i] <= '1;
      end
      smp_cnt_q <= '0;
    end else if (bus.ce) begin
      st_q[bus.slot]  <= st_nxt;
      lvl_q[bus.slot] <= lvl_nxt;
      if (bus.slot == 5'd31) smp_cnt_q <= smp_cnt_q + 13'd1;
    end
  end

  // Output strobe and slot monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.evol      <= 10'h3FF;
      bus.est       <= 2'b11;
      bus.out_slot  <= 5'd0;
      bus.out_valid <= 1'b0;
      bus.mon_eg    <= 5'h1F;
      bus.mon_sgc   <= 2'b11;
    end else begin
      bus.out_valid <= bus.ce;
      if (bus.ce) begin
        bus.evol     <= evol_nxt;
        bus.est      <= st_nxt;
        bus.out_slot <= bus.slot;
        if (bus.slot == bus.mslc) begin
          bus.mon_eg  <= evol_nxt[9:5];
          bus.mon_sgc <= st_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_scsp_eg.sv
// Directed bench for scsp_eg: per-slot parameter tables, one sample = 32 back-to-back CEs.
module tb_scsp_eg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  scsp_eg_if bus ();

  scsp_eg u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int samp   = 0;
  int strobe_bad = 0;

  logic [4:0] ar_a [32], d1r_a [32], d2r_a [32], rr_a [32], dl_a [32];
  logic [3:0] krs_a [32], oct_a [32];
  logic       eghold_a [32], lpslnk_a [32];
  logic       kon_a [32], koff_a [32], loop_a [32];
  logic [9:0] cap_evol [32];
  logic [1:0] cap_est  [32];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input int s, input logic [9:0] ev, input logic [1:0] st);
    chk($sformatf("evol s%0d c%0d", s, samp - 1), 16'(cap_evol[s]), 16'(ev));
    chk($sformatf("est s%0d c%0d", s, samp - 1), 16'(cap_est[s]), 16'(st));
  endtask

  task automatic drive(input int s);
    bus.ce     = 1'b1;
    bus.slot   = 5'(s);
    bus.kon    = kon_a[s];
    bus.koff   = koff_a[s];
    bus.ar     = ar_a[s];
    bus.d1r    = d1r_a[s];
    bus.d2r    = d2r_a[s];
    bus.rr     = rr_a[s];
    bus.dl     = dl_a[s];
    bus.eghold = eghold_a[s];
    bus.lpslnk = lpslnk_a[s];
    bus.krs    = krs_a[s];
    bus.oct    = oct_a[s];
    bus.loop   = loop_a[s];
  endtask

  task automatic capture(input int s);
    cap_evol[s] = bus.evol;
    cap_est[s]  = bus.est;
    if (bus.out_valid !== 1'b1 || bus.out_slot !== 5'(s)) strobe_bad++;
  endtask

  task automatic idle_inputs();
    bus.ce = 1'b0; bus.kon = 1'b0; bus.koff = 1'b0; bus.loop = 1'b0;
    // Junk on non-CE cycles must not matter.
    bus.slot = 5'(samp); bus.ar = 5'd31; bus.rr = 5'd31;
  endtask

  // One full sample; captured strobes land in cap_*; key events are one-shot.
  task automatic run_sample();
    strobe_bad = 0;
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      if (s > 0) capture(s - 1);
      drive(s);
    end
    @(negedge clk);
    capture(31);
    idle_inputs();
    for (int s = 0; s < 32; s++) begin
      kon_a[s] = 1'b0; koff_a[s] = 1'b0; loop_a[s] = 1'b0;
    end
    samp++;
    chk($sformatf("strobes c%0d", samp - 1), 16'(strobe_bad), 16'd0);
  endtask

  task automatic run_to(input int c);
    while (samp <= c) run_sample();
  endtask

  initial begin
    for (int s = 0; s < 32; s++) begin
      ar_a[s] = 0; d1r_a[s] = 0; d2r_a[s] = 0; rr_a[s] = 0; dl_a[s] = 0;
      krs_a[s] = 4'hF; oct_a[s] = 4'h0; eghold_a[s] = 0; lpslnk_a[s] = 0;
      kon_a[s] = 0; koff_a[s] = 0; loop_a[s] = 0;
    end
    bus.mslc = 5'd5;
    bus.eghold = 0; bus.lpslnk = 0; bus.krs = 4'hF; bus.oct = 0;
    bus.d1r = 0; bus.d2r = 0; bus.dl = 0;
    idle_inputs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst evol", 16'(bus.evol), 16'h3FF);
    chk("rst est", 16'(bus.est), 16'h3);
    chk("rst out_slot", 16'(bus.out_slot), 16'h0);
    chk("rst out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst mon_eg", 16'(bus.mon_eg), 16'h1F);
    chk("rst mon_sgc", 16'(bus.mon_sgc), 16'h3);
    rst_n = 1'b1;

    // Sample 0: no key-on, everything silent in release.
    run_sample();
    for (int s = 0; s < 32; s++) chk_slot(s, 10'h3FF, 2'b11);
    @(negedge clk);
    chk("idle out_valid", 16'(bus.out_valid), 16'h0);
    chk("idle hold evol", 16'(bus.evol), 16'h3FF);
    chk("idle hold slot", 16'(bus.out_slot), 16'd31);

    // Sample 1: key-on set-up.
    ar_a[3] = 31; dl_a[3] = 31; kon_a[3] = 1;
    ar_a[5] = 31; d1r_a[5] = 31; dl_a[5] = 4; kon_a[5] = 1;
    ar_a[7] = 31; d1r_a[7] = 31; dl_a[7] = 31; rr_a[7] = 24; kon_a[7] = 1;
    ar_a[2] = 31; d1r_a[2] = 31; dl_a[2] = 31; kon_a[2] = 1;
    eghold_a[9] = 1; kon_a[9] = 1; koff_a[9] = 1;
    ar_a[11] = 31; d1r_a[11] = 20; krs_a[11] = 4; oct_a[11] = 4'h3; dl_a[11] = 31; kon_a[11] = 1;
    ar_a[13] = 31; d1r_a[13] = 28; krs_a[13] = 8; oct_a[13] = 4'h8; dl_a[13] = 31; kon_a[13] = 1;
    ar_a[15] = 31; d1r_a[15] = 16; krs_a[15] = 14; oct_a[15] = 4'h7; dl_a[15] = 31; kon_a[15] = 1;
    ar_a[17] = 31; d1r_a[17] = 20; dl_a[17] = 31; kon_a[17] = 1;
    ar_a[19] = 28; kon_a[19] = 1;
    run_sample();
    chk_slot(3, 10'h000, 2'b01);
    chk_slot(5, 10'h000, 2'b01);
    chk_slot(9, 10'h000, 2'b00);
    chk_slot(11, 10'h000, 2'b01);
    chk_slot(17, 10'h000, 2'b01);
    chk_slot(19, 10'h3BF, 2'b00);
    chk_slot(0, 10'h3FF, 2'b11);
    chk("mon_eg c1", 16'(bus.mon_eg), 16'h00);
    chk("mon_sgc c1", 16'(bus.mon_sgc), 16'h1);

    run_sample();
    chk_slot(19, 10'h383, 2'b00);
    chk_slot(13, 10'h004, 2'b01);
    chk_slot(15, 10'h008, 2'b01);
    chk_slot(11, 10'h002, 2'b01);
    chk_slot(17, 10'h000, 2'b01);
    chk_slot(9, 10'h000, 2'b00);
    chk_slot(5, 10'h008, 2'b01);

    koff_a[9] = 1;
    run_sample();
    chk_slot(9, 10'h3FF, 2'b11);
    chk_slot(11, 10'h004, 2'b01);
    chk_slot(17, 10'h000, 2'b01);
    chk_slot(5, 10'h010, 2'b01);

    run_sample();
    chk_slot(17, 10'h001, 2'b01);
    run_to(7);
    chk_slot(17, 10'h001, 2'b01);
    run_sample();
    chk_slot(17, 10'h002, 2'b01);
    chk_slot(3, 10'h000, 2'b01);

    run_to(16);
    chk_slot(5, 10'h078, 2'b01);
    run_sample();
    chk_slot(5, 10'h080, 2'b10);
    chk("mon_eg c17", 16'(bus.mon_eg), 16'h04);
    chk("mon_sgc c17", 16'(bus.mon_sgc), 16'h2);
    run_sample();
    chk_slot(5, 10'h080, 2'b10);

    // Slot 7: release from mid-decay.
    run_to(33);
    chk_slot(7, 10'h100, 2'b01);
    koff_a[7] = 1;
    run_sample();
    chk_slot(7, 10'h101, 2'b11);
    run_sample();
    chk_slot(7, 10'h102, 2'b11);

    // Slot 2: loop-linked attack releases to decay1 at whatever level.
    run_to(65);
    chk_slot(2, 10'h200, 2'b01);
    ar_a[2] = 10; lpslnk_a[2] = 1; kon_a[2] = 1;
    run_sample();
    chk_slot(2, 10'h200, 2'b00);
    loop_a[2] = 1;
    run_sample();
    chk_slot(2, 10'h200, 2'b01);
    run_sample();
    chk_slot(2, 10'h208, 2'b01);

    run_to(799);
    chk_slot(7, 10'h3FE, 2'b11);
    run_sample();
    chk_slot(7, 10'h3FF, 2'b11);
    run_sample();
    chk_slot(7, 10'h3FF, 2'b11);

    // Asynchronous reset in the middle of a sample.
    @(negedge clk); drive(2);
    @(negedge clk); drive(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst evol", 16'(bus.evol), 16'h3FF);
    chk("mid rst est", 16'(bus.est), 16'h3);
    chk("mid rst out_slot", 16'(bus.out_slot), 16'h0);
    chk("mid rst out_valid", 16'(bus.out_valid), 16'h0);
    chk("mid rst mon_eg", 16'(bus.mon_eg), 16'h1F);
    chk("mid rst mon_sgc", 16'(bus.mon_sgc), 16'h3);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    samp = 0;
    run_sample();
    for (int s = 0; s < 32; s++) chk_slot(s, 10'h3FF, 2'b11);
    chk("post rst mon_eg", 16'(bus.mon_eg), 16'h1F);
    chk("post rst mon_sgc", 16'(bus.mon_sgc), 16'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/scsp_eg.md
SCSP_EG -- requirements
Module: scsp_eg

Interface
REQ-001 CLK  in  1  system clock; every register of the block is clocked by CLK.
REQ-002 RST_N  in  1  reset, asynchronous and active-low.
REQ-003 CE  in  1  slot-processing enable: one pulse per slot time, 32 pulses per sample.
REQ-004 SLOT  in  5  slot being processed on this CE.
REQ-005 KON / KOFF  in  1 / 1  key-on / key-off event for SLOT, sampled on CE only.
REQ-006 AR, D1R, D2R, RR  in  5 each  attack, decay1, decay2 and release rates for SLOT.
REQ-007 DL  in  5  decay level; EGHOLD  in  1  attack-hold; LPSLNK  in  1  loop-start link.
REQ-008 KRS  in  4  key rate scale; OCT  in  4  signed octave for SLOT.
REQ-009 LOOP  in  1  the phase stage has passed the loop start of SLOT on this CE.
REQ-010 MSLC  in  5  slot selected for monitoring.
REQ-011 EVOL  out  10  envelope attenuation for OUT_SLOT: 0 = full volume, 0x3FF = silent.
REQ-012 EST  out  2  envelope state for OUT_SLOT: 00 attack, 01 decay1, 10 decay2, 11 release.
REQ-013 OUT_SLOT  out  5  slot that EVOL and EST refer to.
REQ-014 OUT_VALID  out  1  one-cycle strobe marking EVOL, EST and OUT_SLOT as valid.
REQ-015 MON_EG  out  5  EVOL[9:5] of slot MSLC; MON_SGC  out  2  state of slot MSLC.

Function
REQ-016 Per-slot storage SHALL be 32 entries, each holding a 10-bit level and a 2-bit state; the block SHALL read and write entry SLOT only on a CE cycle.
REQ-017 Output timing: EVOL, EST and OUT_SLOT SHALL be registered, with OUT_VALID high for exactly the cycle after each CE.
- EVOL and EST carry the post-update values.
- Outputs hold their values between strobes.
REQ-018 Sample counter: a 13-bit counter SHALL increment on each CE with SLOT=31, after that slot is processed, and wrap from 0x1FFF to 0.
REQ-019 Active rate R is selected by state: AR, D1R, D2R or RR.
REQ-020 Key scale: if KRS=0xF then KS=0; otherwise T = KRS + sign-extended OCT (6 bits), and KS = 0 if T<0, 0xF if T>15, else T[3:0].
REQ-021 Effective rate: ER = min(31, R+KS).
REQ-022 Step gating: SH = (24 - min(ER,24)) >> 1; a slot SHALL step only when the low SH bits of the sample counter are all zero.
REQ-023 If R=0, the level SHALL NOT change in any state.
REQ-024 Step size: for ER ≤ 24 the step is 1; for ER > 24 the step is 1 << ((ER-24) >> 1).
REQ-025 ATTACK: level -= (level>>4)+1, saturating at 0; if ER ≥ 30, level SHALL be set to 0 on the first stepping CE.
REQ-026 ATTACK → DECAY1 when level reaches 0 and LPSLNK=0; with LPSLNK=1, the transition happens only on LOOP=1, at whatever level.
REQ-027 DECAY1: level += step; DECAY1 → DECAY2 once level[9:5] ≥ DL.
REQ-028 DECAY2 and RELEASE: level += step, saturating at 0x3FF; both states persist at 0x3FF.
REQ-029 Key-on: KON SHALL set state ATTACK with the level unchanged, evaluated in the same CE.
REQ-030 Key-off: KOFF SHALL set state RELEASE from any state.
REQ-031 If KON and KOFF are both high, KON SHALL win.
REQ-032 EGHOLD=1 while in ATTACK: EVOL output SHALL be 0, while the stored level keeps its normal update.
REQ-033 MON_EG and MON_SGC SHALL be registered and refreshed on the CE where SLOT=MSLC.
REQ-034 CE and SLOT SHALL be the only qualifiers: inputs on non-CE cycles have no effect.
REQ-035 Arithmetic SHALL be unsigned 11-bit with clamping to [0, 0x3FF]; no wrap-around of level is permitted.

Reset
REQ-036 RST_N low SHALL asynchronously set every slot to level 0x3FF and state RELEASE.
REQ-037 RST_N low SHALL clear the sample counter, EVOL (0x3FF), EST (11), OUT_SLOT, OUT_VALID, MON_EG (0x1F) and MON_SGC (11).
REQ-038 Reset mid-envelope SHALL discard all state; the first CE after release SHALL behave as from power-up.

Verification
REQ-039 Reset then one full sample with no KON -> all 32 strobes show EVOL=0x3FF, EST=11.
REQ-040 Slot 3: KON, AR=31, D1R=0, EGHOLD=0 -> next stepping CE gives EVOL=0, EST=01; level stays 0 while D1R=0.
REQ-041 Slot 5: KON, AR=31, D1R=31, DL=4, KRS=0xF -> level stays 0 in attack.
- Decay1 then steps by 8 every sample.
- EST becomes 10 once EVOL[9:5] ≥ 4, i.e. EVOL ≥ 0x080.
REQ-042 Slot 7 mid-decay at 0x100: KOFF, RR=24, KRS=0xF -> EST=11 and level rises by 1 per sample (SH=0) until it holds at 0x3FF.
REQ-043 Slot 9: KON and KOFF on the same CE -> EST=00; with EGHOLD=1, EVOL=0 throughout attack.
REQ-044 Slot 2: LPSLNK=1, AR=10 in attack, LOOP=1 at level 0x200 -> EST=01 with EVOL=0x200; RST_N pulsed mid-run -> all outputs return to reset values immediately.
